objline_serializer: RTL and testbench
=====================================

OBJLINE_SERIALIZER -- requirements
Module: objline_serializer

Interface
REQ-001 Parameter PX_BITS, default 4: bits per pixel.
REQ-002 Parameter PX_PER_LINE, default 8: pixels per tile line; power of two, 2..16.
REQ-003 Parameter PAL_BITS, default 4: palette code width.
REQ-004 Port i_EMU_MCLK  in  1: the single clock; all state changes on its rising edge.
REQ-005 Port i_EMU_RST_n  in  1: asynchronous active-low reset.
REQ-006 Port i_EMU_CLK6MPCEN_n  in  1: active-low clock enable; state advances only on enabled edges.
REQ-007 Port i_GFXDATA  in  PX_BITS*PX_PER_LINE: tile line; pixel 0 in MSBs.
REQ-008 Port i_OC  in  PAL_BITS: palette code for the offered line.
REQ-009 Port i_HFLIP  in  1: emit offered line in reverse order.
REQ-010 Port i_LAST  in  1: offered line is the last of the object strip.
REQ-011 Port i_XPOS_D0  in  1: X parity of the first pixel of a strip; sampled only when loading from IDLE.
REQ-012 Port i_GFXVALID  in  1: offered line valid.
REQ-013 Port o_GFXREADY  out  1: line slot free; a transfer occurs on an enabled edge with valid and ready both high.
REQ-014 Port o_AD / o_BD  out  PAL_BITS+PX_BITS each: {palette, pixel} for the even / odd X bank.
REQ-015 Port o_AWE_n / o_BWE_n  out  1 each: active-low bank write enables.
REQ-016 Port o_WR_n  out  1: active-low pair write strobe, one enabled cycle wide.
REQ-017 Port o_BUSY  out  1: high in any state other than IDLE.

Function
REQ-018 Two line buffers (front, back), each holding data, palette, HFLIP and LAST.
REQ-019 States: IDLE, EMIT, STALL, FLUSH.
REQ-020 IDLE: o_GFXREADY=1; a transfer loads front, sets parity p to i_XPOS_D0, sets pixel index to 0, and moves to EMIT.
REQ-021 EMIT: each enabled edge processes one pixel, index idx; selected pixel = HFLIP ? PX_PER_LINE-1-idx : idx.
REQ-022 After each processed pixel, p toggles.
REQ-023 p=0: pixel is stored, with front palette, in the A-hold register; a-pending is set.
REQ-024 p=1 update at the same edge: o_AD = A-hold (or 0 with o_AWE_n=1 if a-pending is clear); o_BD = current pixel; o_WR_n=0; a-pending cleared.
REQ-025 Transparency: any pixel value 0 forces its bank WE_n to 1; the data field is still driven.
REQ-026 idx wraps at PX_PER_LINE-1.
REQ-027 At the wrap, if back is full: back moves to front in the same edge; the next pixel is processed on the next enabled edge with no bubble; p continues.
REQ-028 At the wrap, if back is empty and front LAST=1: go to FLUSH if a-pending will be set, otherwise IDLE.
REQ-029 At the wrap, if back is empty and LAST=0: go to STALL.
REQ-030 STALL: no strobes; p and A-hold are retained; a transfer loads front and returns to EMIT.
REQ-031 FLUSH: one strobe with o_AD = A-hold, o_BWE_n=1, o_BD=0; then IDLE.
REQ-032 In EMIT, o_GFXREADY = back empty; a transfer fills back.
REQ-033 A transfer and a swap on the same edge are legal: the incoming line goes directly to front.
REQ-034 o_WR_n returns high on the next enabled edge after any strobe.
REQ-035 o_AD, o_BD and the WE_n outputs hold their values between strobes.
REQ-036 Disabled edges change nothing.

Reset
REQ-037 Reset asserted: state IDLE; both buffers empty; p=0; a-pending=0; o_AD=o_BD=0; o_AWE_n=o_BWE_n=o_WR_n=1; o_BUSY=0.
REQ-038 o_GFXREADY=0 while reset is asserted and 1 after release.
REQ-039 Reset mid-strip aborts immediately with no flush strobe.

Structure
REQ-040 A shared package holds the state enum, the line-buffer record type, and the widths PIX_W = PAL_BITS+PX_BITS and LINE_W = PX_BITS*PX_PER_LINE.
REQ-041 One sub-module, objline_pixsel: combinational flip-aware pixel selector (line, idx, hflip -> pixel).

Verification
Defaults: PX_BITS=4, PX_PER_LINE=8, PAL_BITS=4, enable every cycle, transfer accepted at edge T.
REQ-042 Data 0x12345678, OC=A, D0=0, HFLIP=0, LAST=1 -> strobes after T+2, T+4, T+6, T+8 with (AD,BD) = (A1,A2), (A3,A4), (A5,A6), (A7,A8); all WE_n=0; BUSY low after T+8.
REQ-043 Same line with D0=1 -> strobe after T+1 with AWE_n=1 and BD=A1; then (A2,A3), (A4,A5), (A6,A7); flush strobe after T+9 with AD=A8, BWE_n=1.
REQ-044 HFLIP=1, D0=0 -> pairs (A8,A7), (A6,A5), (A4,A3), (A2,A1).
REQ-045 Data 0x10203040, D0=0 -> every strobe has BWE_n=1 and AWE_n=0; AD = A1, A2, A3, A4.
REQ-046 Second line 0x9ABCDEF1 with OC=5 and LAST=1, offered while the first line (LAST=0) emits:
- READY falls after acceptance.
- Pixel 0 of line 2 is processed at T+9 with no bubble.
- The pair after T+10 is (59,5A).
- There are 8 strobes in total.
REQ-047 Line with LAST=0 and no follow-up -> STALL, BUSY=1, no strobe for 20 cycles.
REQ-048 Reset during EMIT -> outputs take their reset values immediately, and the next line starts cleanly from IDLE.

Source files
------------

// File: rtl/objline_serializer_pkg.sv
// objline_serializer_pkg
//   Shared types and widths for the object line serializer.
//   - objline_state_e : serializer FSM states
//   - line_buf_t      : one line slot (pixel data, palette, flip, last flag)
//   - PIX_W / LINE_W  : {palette,pixel} word width and packed tile line width
//   The line record is sized from the DEF_* constants below, so a build that
//   changes the pixel geometry changes these constants together with the
//   module parameters.
package objline_serializer_pkg;

    localparam int unsigned DEF_PX_BITS     = 4;
    localparam int unsigned DEF_PX_PER_LINE = 8;
    localparam int unsigned DEF_PAL_BITS    = 4;

    localparam int unsigned PIX_W  = DEF_PAL_BITS + DEF_PX_BITS;
    localparam int unsigned LINE_W = DEF_PX_BITS * DEF_PX_PER_LINE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } objline_state_e;

    typedef struct packed {
        logic [LINE_W-1:0]       data;
        logic [DEF_PAL_BITS-1:0] pal;
        logic                    hflip;
        logic                    last;
    } line_buf_t;

endpackage

// File: rtl/objline_pixsel.sv
// objline_pixsel
//   Combinational flip-aware pixel selector.
//   line  : packed tile line, pixel 0 in the MSBs
//   idx   : emission index (0 .. PX_PER_LINE-1)
//   hflip : select pixels in reverse order
//   pixel : selected pixel value
module objline_pixsel
    import objline_serializer_pkg::*;
#(
    parameter  int unsigned PX_BITS     = DEF_PX_BITS,
    parameter  int unsigned PX_PER_LINE = DEF_PX_PER_LINE,
    localparam int unsigned IDX_W       = $clog2(PX_PER_LINE)
) (
    input  logic [PX_BITS*PX_PER_LINE-1:0] line,
    input  logic [IDX_W-1:0]               idx,
    input  logic                           hflip,
    output logic [PX_BITS-1:0]             pixel
);

    logic [IDX_W-1:0] sel;

    always_comb begin
        // PX_PER_LINE is a power of two, so PX_PER_LINE-1-idx is ~idx
        sel   = hflip ? ~idx : idx;
        pixel = '0;
        for (int unsigned i = 0; i < PX_PER_LINE; i++) begin
            if (sel == IDX_W'(i)) begin
                pixel = line[(PX_PER_LINE-1-i)*PX_BITS +: PX_BITS];
            end
        end
    end

endmodule

// File: rtl/objline_serializer.sv
// objline_serializer
//   Serializes object tile lines into even/odd X bank write pairs.
//   Ports:
//     i_EMU_MCLK         : clock (rising edge)
//     i_EMU_RST_n        : asynchronous active-low reset
//     i_EMU_CLK6MPCEN_n  : active-low clock enable
//     i_GFXDATA          : offered tile line, pixel 0 in MSBs
//     i_OC               : palette code of the offered line
//     i_HFLIP            : emit the offered line reversed
//     i_LAST             : offered line ends the object strip
//     i_XPOS_D0          : X parity of the first pixel (sampled from IDLE)
//     i_GFXVALID         : offered line valid
//     o_GFXREADY         : line slot free
//     o_AD / o_BD        : {palette,pixel} for the even / odd bank
//     o_AWE_n / o_BWE_n  : active-low bank write enables (1 for transparent)
//     o_WR_n             : active-low pair write strobe
//     o_BUSY             : serializer not idle
module objline_serializer
    import objline_serializer_pkg::*;
#(
    parameter  int unsigned PX_BITS     = DEF_PX_BITS,
    parameter  int unsigned PX_PER_LINE = DEF_PX_PER_LINE,
    parameter  int unsigned PAL_BITS    = DEF_PAL_BITS,
    localparam int unsigned IDX_W       = $clog2(PX_PER_LINE)
) (
    input  logic                           i_EMU_MCLK,
    input  logic                           i_EMU_RST_n,
    input  logic                           i_EMU_CLK6MPCEN_n,
    input  logic [PX_BITS*PX_PER_LINE-1:0] i_GFXDATA,
    input  logic [PAL_BITS-1:0]            i_OC,
    input  logic                           i_HFLIP,
    input  logic                           i_LAST,
    input  logic                           i_XPOS_D0,
    input  logic                           i_GFXVALID,
    output logic                           o_GFXREADY,
    output logic [PAL_BITS+PX_BITS-1:0]    o_AD,
    output logic [PAL_BITS+PX_BITS-1:0]    o_BD,
    output logic                           o_AWE_n,
    output logic                           o_BWE_n,
    output logic                           o_WR_n,
    output logic                           o_BUSY
);

    objline_state_e state, state_nxt;
    line_buf_t      front, front_nxt;
    line_buf_t      back, back_nxt;
    line_buf_t      in_line;
    logic           back_full, back_full_nxt;
    logic           p, p_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [PIX_W-1:0] a_hold, a_hold_nxt;
    logic           a_pend, a_pend_nxt;

    logic [PAL_BITS+PX_BITS-1:0] ad_nxt, bd_nxt;
    logic           awe_n_nxt, bwe_n_nxt, wr_n_nxt;

    logic           en;
    logic           ready_c;
    logic           xfer;
    logic           wrap;
    logic [PX_BITS-1:0]          pix;
    logic [PAL_BITS+PX_BITS-1:0] pix_word;

    assign en       = ~i_EMU_CLK6MPCEN_n;
    assign in_line  = {i_GFXDATA, i_OC, i_HFLIP, i_LAST};
    assign wrap     = (idx == IDX_W'(PX_PER_LINE-1));
    assign pix_word = {front.pal, pix};

    objline_pixsel #(
        .PX_BITS     (PX_BITS),
        .PX_PER_LINE (PX_PER_LINE)
    ) u_pixsel (
        .line  (front.data),
        .idx   (idx),
        .hflip (front.hflip),
        .pixel (pix)
    );

    // Ready is forced low while reset is held so no line is taken mid-reset.
    assign o_GFXREADY = ready_c & i_EMU_RST_n;
    assign o_BUSY     = (state != ST_IDLE);

    always_comb begin
        state_nxt     = state;
        front_nxt     = front;
        back_nxt      = back;
        back_full_nxt = back_full;
        p_nxt         = p;
        idx_nxt       = idx;
        a_hold_nxt    = a_hold;
        a_pend_nxt    = a_pend;
        ad_nxt        = o_AD;
        bd_nxt        = o_BD;
        awe_n_nxt     = o_AWE_n;
        bwe_n_nxt     = o_BWE_n;
        wr_n_nxt      = 1'b1;
        ready_c       = 1'b0;
        xfer          = 1'b0;

        case (state)
            ST_IDLE: begin
                ready_c = 1'b1;
                xfer    = i_GFXVALID;
                if (xfer) begin
                    front_nxt = in_line;
                    p_nxt     = i_XPOS_D0;
                    idx_nxt   = '0;
                    state_nxt = ST_EMIT;
                end
            end

            ST_EMIT: begin
                ready_c = ~back_full;
                xfer    = i_GFXVALID & ~back_full;

                if (!p) begin
                    a_hold_nxt = pix_word;
                    a_pend_nxt = 1'b1;
                end else begin
                    ad_nxt     = a_pend ? a_hold : '0;
                    awe_n_nxt  = ~a_pend | (a_hold[PX_BITS-1:0] == '0);
                    bd_nxt     = pix_word;
                    bwe_n_nxt  = (pix == '0);
                    wr_n_nxt   = 1'b0;
                    a_pend_nxt = 1'b0;
                end
                p_nxt   = ~p;
                idx_nxt = idx + IDX_W'(1);

                if (wrap) begin
                    // Next line continues the strip without a bubble: either the
                    // queued back line, or a line arriving on this very edge
                    // (back is empty then, so it bypasses straight to front).
                    if (back_full) begin
                        front_nxt     = back;
                        back_full_nxt = 1'b0;
                    end else if (xfer) begin
                        front_nxt = in_line;
                    end else if (front.last) begin
                        state_nxt = a_pend_nxt ? ST_FLUSH : ST_IDLE;
                    end else begin
                        state_nxt = ST_STALL;
                    end
                end else if (xfer) begin
                    back_nxt      = in_line;
                    back_full_nxt = 1'b1;
                end
            end

            ST_STALL: begin
                ready_c = 1'b1;
                xfer    = i_GFXVALID;
                if (xfer) begin
                    front_nxt = in_line;
                    idx_nxt   = '0;
                    state_nxt = ST_EMIT;
                end
            end

            ST_FLUSH: begin
                ad_nxt     = a_hold;
                awe_n_nxt  = (a_hold[PX_BITS-1:0] == '0);
                bd_nxt     = '0;
                bwe_n_nxt  = 1'b1;
                wr_n_nxt   = 1'b0;
                a_pend_nxt = 1'b0;
                state_nxt  = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            state     <= ST_IDLE;
            front     <= '0;
            back      <= '0;
            back_full <= 1'b0;
            p         <= 1'b0;
            idx       <= '0;
            a_hold    <= '0;
            a_pend    <= 1'b0;
            o_AD      <= '0;
            o_BD      <= '0;
            o_AWE_n   <= 1'b1;
            o_BWE_n   <= 1'b1;
            o_WR_n    <= 1'b1;
        end else if (en) begin
            state     <= state_nxt;
            front     <= front_nxt;
            back      <= back_nxt;
            back_full <= back_full_nxt;
            p         <= p_nxt;
            idx       <= idx_nxt;
            a_hold    <= a_hold_nxt;
            a_pend    <= a_pend_nxt;
            o_AD      <= ad_nxt;
            o_BD      <= bd_nxt;
            o_AWE_n   <= awe_n_nxt;
            o_BWE_n   <= bwe_n_nxt;
            o_WR_n    <= wr_n_nxt;
        end
    end

endmodule

// File: tb/tb_objline_serializer.sv
module tb_objline_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_n;
    logic [31:0] gfxdata;
    logic [3:0]  oc;
    logic        hflip, last, d0, valid;
    logic        ready;
    logic [7:0]  ad, bd;
    logic        awe_n, bwe_n, wr_n, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [17:0] exp_q[$];     // {AD, AWE_n, BD, BWE_n}
    int          strobe_t[$];  // edge index of each observed strobe
    logic [7:0]  strip_px[$];  // {pal,pix} words of the strip being built
    bit          rand_en = 1'b0;

    int          T, T2, ti;
    logic [31:0] ld[3];
    logic [3:0]  lp[3];
    logic        lh[3];

    objline_serializer #(
        .PX_BITS     (4),
        .PX_PER_LINE (8),
        .PAL_BITS    (4)
    ) dut (
        .i_EMU_MCLK        (clk),
        .i_EMU_RST_n       (rst_n),
        .i_EMU_CLK6MPCEN_n (en_n),
        .i_GFXDATA         (gfxdata),
        .i_OC              (oc),
        .i_HFLIP           (hflip),
        .i_LAST            (last),
        .i_XPOS_D0         (d0),
        .i_GFXVALID        (valid),
        .o_GFXREADY        (ready),
        .o_AD              (ad),
        .o_BD              (bd),
        .o_AWE_n           (awe_n),
        .o_BWE_n           (bwe_n),
        .o_WR_n            (wr_n),
        .o_BUSY            (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Enable driver: always on in directed tests, ~75% in random tests.
    initial begin
        en_n = 1'b0;
        forever begin
            @(negedge clk);
            en_n = rand_en ? ($urandom_range(3) == 0) : 1'b0;
        end
    end

    // Monitor: one comparison per strobe on an enabled edge.
    logic mon_en, mon_rst;
    initial begin
        forever begin
            @(posedge clk);
            mon_en  = ~en_n;
            mon_rst = rst_n;
            #1;
            if (mon_rst && rst_n && mon_en && !wr_n) begin
                strobe_t.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got %0h at edge %0d, required no strobe",
                             {ad, awe_n, bd, bwe_n}, cyc);
                end else begin
                    chk("strobe", {ad, awe_n, bd, bwe_n}, exp_q.pop_front());
                end
            end
        end
    end

    function automatic logic tr(input logic [7:0] w);
        return (w[3:0] == 4'h0);
    endfunction

    // Reference model: append a line's pixels in emission order.
    task automatic add_line(input logic [31:0] d, input logic [3:0] pal, input logic hf);
        int j;
        logic [31:0] t;
        for (int i = 0; i < 8; i++) begin
            j = hf ? 7 - i : i;
            t = d >> (4 * (7 - j));
            strip_px.push_back({pal, t[3:0]});
        end
    endtask

    // Reference model: pixel k sits at X parity (d0+k)&1; even pixel pairs with
    // the following odd one; lone leading odd / trailing even pixels get a blank partner.
    task automatic push_strip(input logic sd0);
        int k = 0;
        int n = strip_px.size();
        if (sd0) begin
            exp_q.push_back({8'h00, 1'b1, strip_px[0], tr(strip_px[0])});
            k = 1;
        end
        while (k < n) begin
            if (k + 1 < n) begin
                exp_q.push_back({strip_px[k], tr(strip_px[k]), strip_px[k+1], tr(strip_px[k+1])});
                k += 2;
            end else begin
                exp_q.push_back({strip_px[k], tr(strip_px[k]), 8'h00, 1'b1});
                k += 1;
            end
        end
        strip_px.delete();
    endtask

    task automatic send_line(input logic [31:0] d, input logic [3:0] pal, input logic hf,
                             input logic lst, input logic sd0, output int t);
        int n = 0;
        @(negedge clk);
        #1;
        gfxdata = d; oc = pal; hflip = hf; last = lst; d0 = sd0; valid = 1'b1;
        while (!(ready && !en_n)) begin
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: ready still 0 after %0d cycles, required 1", n);
                break;
            end
            @(negedge clk);
            #1;
        end
        t = cyc + 1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_idle(output int t);
        int n = 0;
        t = -1;
        while (n < 2000) begin
            @(negedge clk);
            if (!busy) begin
                t = cyc;
                break;
            end
            n++;
        end
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ad"},    ad,    8'h00);
        chk({tag, "_bd"},    bd,    8'h00);
        chk({tag, "_we"},    {awe_n, bwe_n, wr_n}, 3'b111);
        chk({tag, "_busy"},  busy,  1'b0);
        chk({tag, "_ready"}, ready, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        gfxdata = '0; oc = '0; hflip = 1'b0; last = 1'b0; d0 = 1'b0; valid = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 chk_reset_outs("reset");
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("ready_after_reset", ready, 1'b1);

        // Straight line, even start
        add_line(32'h12345678, 4'hA, 1'b0); push_strip(1'b0);
        strobe_t.delete();
        send_line(32'h12345678, 4'hA, 1'b0, 1'b1, 1'b0, T);
        wait_idle(ti);
        chk("even_nstrobes", strobe_t.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("even_t%0d", i), strobe_t[i], T + 2 + 2 * i);
        chk("even_idle", ti, T + 8);

        // Odd start: leading lone B write and trailing flush
        add_line(32'h12345678, 4'hA, 1'b0); push_strip(1'b1);
        strobe_t.delete();
        send_line(32'h12345678, 4'hA, 1'b0, 1'b1, 1'b1, T);
        wait_idle(ti);
        chk("odd_nstrobes", strobe_t.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("odd_t%0d", i), strobe_t[i], T + 1 + 2 * i);
        chk("odd_idle", ti, T + 9);

        // Flipped line
        add_line(32'h12345678, 4'hA, 1'b1); push_strip(1'b0);
        send_line(32'h12345678, 4'hA, 1'b1, 1'b1, 1'b0, T);
        wait_idle(ti);
        chk("flip_idle", ti, T + 8);

        // Transparent odd pixels
        add_line(32'h10203040, 4'hA, 1'b0); push_strip(1'b0);
        send_line(32'h10203040, 4'hA, 1'b0, 1'b1, 1'b0, T);
        wait_idle(ti);

        // Back-to-back lines: swap without a bubble
        add_line(32'h12345678, 4'hA, 1'b0); add_line(32'h9ABCDEF1, 4'h5, 1'b0); push_strip(1'b0);
        strobe_t.delete();
        send_line(32'h12345678, 4'hA, 1'b0, 1'b0, 1'b0, T);
        send_line(32'h9ABCDEF1, 4'h5, 1'b0, 1'b1, 1'b0, T2);
        chk("b2b_accept", T2, T + 1);
        chk("b2b_ready_fall", ready, 1'b0);
        wait_idle(ti);
        chk("b2b_nstrobes", strobe_t.size(), 8);
        chk("b2b_pair5_t", strobe_t[4], T + 10);
        chk("b2b_idle", ti, T + 16);

        // Stall after a non-last line, then resume with a-hold retained
        add_line(32'h12345678, 4'hA, 1'b0); add_line(32'h9ABCDEF1, 4'h5, 1'b1); push_strip(1'b1);
        strobe_t.delete();
        send_line(32'h12345678, 4'hA, 1'b0, 1'b0, 1'b1, T);
        repeat (8) @(negedge clk);
        chk("stall_n_before", strobe_t.size(), 4);
        repeat (20) @(negedge clk);
        chk("stall_n_after", strobe_t.size(), 4);
        chk("stall_busy", busy, 1'b1);
        chk("stall_ready", ready, 1'b1);
        send_line(32'h9ABCDEF1, 4'h5, 1'b1, 1'b1, 1'b1, T);
        wait_idle(ti);
        chk("stall_total", strobe_t.size(), 9);

        // Reset during EMIT
        add_line(32'h12345678, 4'hA, 1'b0); push_strip(1'b0);
        strobe_t.delete();
        send_line(32'h12345678, 4'hA, 1'b0, 1'b1, 1'b0, T);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("midreset");
        chk("midreset_nstrobes", strobe_t.size(), 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("midreset_ready", ready, 1'b1);
        add_line(32'hF0E1D2C3, 4'h3, 1'b1); push_strip(1'b1);
        send_line(32'hF0E1D2C3, 4'h3, 1'b1, 1'b1, 1'b1, T);
        wait_idle(ti);
        chk("midreset_restart_idle", ti, T + 9);

        // Randomized strips with gated enable and gaps between lines
        rand_en = 1'b1;
        for (int s = 0; s < 30; s++) begin
            int   nl;
            logic sd0;
            logic [3:0] nib;
            nl  = $urandom_range(1, 3);
            sd0 = 1'($urandom_range(1));
            for (int i = 0; i < nl; i++) begin
                ld[i] = '0;
                for (int b = 0; b < 8; b++) begin
                    nib   = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    ld[i] = {ld[i][27:0], nib};
                end
                lp[i] = 4'($urandom_range(15));
                lh[i] = 1'($urandom_range(1));
                add_line(ld[i], lp[i], lh[i]);
            end
            push_strip(sd0);
            for (int i = 0; i < nl; i++) begin
                send_line(ld[i], lp[i], lh[i], (i == nl - 1), sd0, T);
                repeat ($urandom_range(0, 12)) @(negedge clk);
            end
            wait_idle(ti);
        end
        rand_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
